// File: rtl/map_probe_arbiter.sv
// Shares the map ROM between the display path and two tank collision probes.
// Returns one verdict per probe. The display preempts probe reads, and a probe only issues a read while vid_active is low.
module map_probe_arbiter #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int TANK_SIZE = 32,
  parameter int ROM_LAT   = 1
) (
  input  logic        clk_25m,
  input  logic        rst,
  input  logic        vid_active,
  input  logic [18:0] vid_addr,
  input  logic [1:0]  req,
  input  logic [9:0]  pos_x0,
  input  logic [9:0]  pos_y0,
  input  logic [9:0]  pos_x1,
  input  logic [9:0]  pos_y1,
  output logic [18:0] map_addr,
  input  logic [7:0]  map_data,
  output logic [1:0]  ack,
  output logic        blocked
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  localparam int WCW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  logic [2:0]     state;
  logic           grant;
  logic           last_grant;
  logic           hit;
  logic [9:0]     px;
  logic [9:0]     py;
  logic [1:0]     idx;
  logic [WCW-1:0] wcnt;
  logic [18:0]    probe_addr;

  logic           pick;
  logic [10:0]    far_x;
  logic [10:0]    far_y;
  logic           oob;
  logic [10:0]    cx;
  logic [10:0]    cy;
  logic [18:0]    corner_addr;
  logic           wait_last;
  logic           rom_hit;
  logic [1:0]     grant_onehot;

  // On a tie the requester that was not served last wins.
  assign pick = (req == 2'b11) ? ~last_grant : req[1];

  // Far edges are 11 bits wide so that a wrapped coordinate still reads as out of bounds.
  assign far_x = {1'b0, px} + 11'(TANK_SIZE - 1);
  assign far_y = {1'b0, py} + 11'(TANK_SIZE - 1);
  assign oob   = (far_x >= 11'(SCREEN_W)) || (far_y >= 11'(SCREEN_H));

  assign cx          = idx[0] ? far_x : {1'b0, px};
  assign cy          = idx[1] ? far_y : {1'b0, py};
  assign corner_addr = 19'(cy) * 19'(SCREEN_W) + 19'(cx);

  assign wait_last    = (wcnt == WCW'(ROM_LAT - 1));
  assign rom_hit      = (map_data != 8'd0);
  assign grant_onehot = grant ? 2'b10 : 2'b01;

  // Display path is purely combinational; the corner address is shown during ISSUE itself.
  assign map_addr = vid_active ? vid_addr :
                    (state == ST_ISSUE) ? corner_addr : probe_addr;

  always_ff @(posedge clk_25m) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      hit        <= 1'b0;
      px         <= 10'd0;
      py         <= 10'd0;
      idx        <= 2'd0;
      wcnt       <= '0;
      probe_addr <= 19'd0;
      ack        <= 2'b00;
      blocked    <= 1'b0;
    end else begin
      ack     <= 2'b00;
      blocked <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req != 2'b00) begin
            grant      <= pick;
            last_grant <= pick;
            px         <= pick ? pos_x1 : pos_x0;
            py         <= pick ? pos_y1 : pos_y0;
            hit        <= 1'b0;
            state      <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (oob) begin
            hit     <= 1'b1;
            ack     <= grant_onehot;
            blocked <= 1'b1;
            state   <= ST_RESP;
          end else begin
            idx   <= 2'd0;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!vid_active) begin
            probe_addr <= corner_addr;
            wcnt       <= '0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // The read is already in flight, so display traffic here does not disturb it.
          if (wait_last) begin
            hit <= hit | rom_hit;
            if (idx == 2'd3) begin
              ack     <= grant_onehot;
              blocked <= hit | rom_hit;
              state   <= ST_RESP;
            end else begin
              idx   <= idx + 2'd1;
              state <= ST_ISSUE;
            end
          end else begin
            wcnt <= wcnt + WCW'(1);
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_map_probe_arbiter.sv
// Directed bench for map_probe_arbiter with a ROM model and a per-cycle verdict checker.
module tb_map_probe_arbiter;

  logic        clk_25m = 1'b0;
  logic        rst;
  logic        vid_active;
  logic [18:0] vid_addr;
  logic [1:0]  req;
  logic [9:0]  pos_x0, pos_y0, pos_x1, pos_y1;
  logic [18:0] map_addr;
  logic [7:0]  map_data = 8'd0;
  logic [1:0]  ack;
  logic        blocked;

  int errors = 0;
  int checks = 0;
  int ack_count = 0;
  bit checking = 1'b0;

  int          vid_pat [0:15];
  int          addr_log [0:40];
  int          n;
  logic [1:0]  a;
  logic        b;
  int          acks_before;

  map_probe_arbiter dut (
    .clk_25m(clk_25m), .rst(rst), .vid_active(vid_active), .vid_addr(vid_addr),
    .req(req), .pos_x0(pos_x0), .pos_y0(pos_y0), .pos_x1(pos_x1), .pos_y1(pos_y1),
    .map_addr(map_addr), .map_data(map_data), .ack(ack), .blocked(blocked)
  );

  always #20 clk_25m = ~clk_25m;

  function automatic bit is_wall(input int addr);
    return (addr == 102491) || (addr == 307199);
  endfunction

  // Verdict straight from the box geometry: out of bounds, or any wall corner.
  function automatic bit model_blocked(input int x, input int y);
    if (x + 31 >= 640 || y + 31 >= 480) return 1'b1;
    return is_wall(y*640 + x) || is_wall(y*640 + x + 31) ||
           is_wall((y+31)*640 + x) || is_wall((y+31)*640 + x + 31);
  endfunction

  // Single-cycle-latency ROM.
  always @(posedge clk_25m) map_data <= is_wall(int'(map_addr)) ? 8'h5A : 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk_25m) begin
    if (!rst && checking) begin
      if (vid_active) chk("vid_mux", int'(map_addr), int'(vid_addr));
      chk("ack_onehot", int'(ack == 2'b11), 0);
      if (ack != 2'b00) begin
        ack_count++;
        chk("verdict_model", int'(blocked),
            int'(ack[1] ? model_blocked(int'(pos_x1), int'(pos_y1))
                        : model_blocked(int'(pos_x0), int'(pos_y0))));
      end
    end
  end

  // Cycle 0 is the cycle in which req is first presented to an idle arbiter.
  task automatic run_probe(input logic [1:0] r, input bit set_req,
                           output int cyc, output logic [1:0] ak, output logic bk);
    if (set_req) req = r;
    vid_active = vid_pat[0] != 0;
    cyc = 0; ak = 2'b00; bk = 1'b0;
    while (ak == 2'b00 && cyc < 40) begin
      @(posedge clk_25m); #1;
      cyc++;
      vid_active = (cyc < 16) ? (vid_pat[cyc] != 0) : 1'b0;
      #1;
      addr_log[cyc] = int'(map_addr);
      ak = ack;
      bk = blocked;
    end
    if (ak == 2'b00) chk("ack_timeout", 0, 1);
    req = req & ~ak;
  endtask

  task automatic gap();
    @(posedge clk_25m); #1;
  endtask

  task automatic clear_pat();
    for (int i = 0; i < 16; i++) vid_pat[i] = 0;
    vid_active = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = 2'b00; vid_active = 1'b0; vid_addr = 19'd0;
    pos_x0 = 10'd0; pos_y0 = 10'd0; pos_x1 = 10'd0; pos_y1 = 10'd0;
    clear_pat();
    repeat (3) @(posedge clk_25m);
    #1 rst = 1'b0;
    #1;
    chk("reset_ack", int'(ack), 0);
    chk("reset_blocked", int'(blocked), 0);
    chk("reset_map_addr", int'(map_addr), 0);
    chk("model_pin_clear", int'(model_blocked(60, 60)), 0);
    chk("model_pin_wall", int'(model_blocked(60, 160)), 1);
    checking = 1'b1;

    // Clear box, requester 0.
    pos_x0 = 10'd60; pos_y0 = 10'd60;
    run_probe(2'b01, 1'b1, n, a, b);
    chk("t1_latency", n, 10); chk("t1_ack", int'(a), 1); chk("t1_blocked", int'(b), 0);
    chk("t1_addr0", addr_log[2], 38460); chk("t1_addr1", addr_log[4], 38491);
    chk("t1_addr2", addr_log[6], 58300); chk("t1_addr3", addr_log[8], 58331);
    gap();

    // Wall on the second corner, requester 1.
    pos_x1 = 10'd60; pos_y1 = 10'd160;
    run_probe(2'b10, 1'b1, n, a, b);
    chk("t2_latency", n, 10); chk("t2_ack", int'(a), 2); chk("t2_blocked", int'(b), 1);
    chk("t2_addr1", addr_log[4], 102491);
    gap();

    // Out of bounds in x: no new address may appear.
    pos_x0 = 10'd620; pos_y0 = 10'd60;
    run_probe(2'b01, 1'b1, n, a, b);
    chk("t3_latency", n, 2); chk("t3_ack", int'(a), 1); chk("t3_blocked", int'(b), 1);
    chk("t3_addr_c1", addr_log[1], 122331); chk("t3_addr_c2", addr_log[2], 122331);
    gap();

    // Largest in-bounds box; the far corner is a wall.
    pos_x0 = 10'd608; pos_y0 = 10'd448;
    run_probe(2'b01, 1'b1, n, a, b);
    chk("t4_latency", n, 10); chk("t4_blocked", int'(b), 1);
    chk("t4_addr3", addr_log[8], 307199);
    gap();

    // Wrapped x (0-1) on requester 0.
    pos_x0 = 10'd1023; pos_y0 = 10'd0;
    run_probe(2'b01, 1'b1, n, a, b);
    chk("t5a_latency", n, 2); chk("t5a_blocked", int'(b), 1);
    gap();

    // One pixel past the bottom edge on requester 1.
    pos_x1 = 10'd608; pos_y1 = 10'd449;
    run_probe(2'b10, 1'b1, n, a, b);
    chk("t5b_latency", n, 2); chk("t5b_ack", int'(a), 2); chk("t5b_blocked", int'(b), 1);
    gap();

    // Tie after requester 1 was served last: requester 0 goes first.
    pos_x0 = 10'd60; pos_y0 = 10'd60; pos_x1 = 10'd100; pos_y1 = 10'd100;
    run_probe(2'b11, 1'b1, n, a, b);
    chk("t6_first_ack", int'(a), 1); chk("t6_first_lat", n, 10);
    run_probe(2'b00, 1'b0, n, a, b);
    chk("t6_second_ack", int'(a), 2); chk("t6_second_lat", n, 11);
    chk("t6_second_blocked", int'(b), 0);
    gap();

    // Serve requester 0 alone, then the tie goes to requester 1.
    run_probe(2'b01, 1'b1, n, a, b);
    gap();
    run_probe(2'b11, 1'b1, n, a, b);
    chk("t7_first_ack", int'(a), 2);
    run_probe(2'b00, 1'b0, n, a, b);
    chk("t7_second_ack", int'(a), 1);
    gap();

    // Display traffic during the probe.
    // Two of the active cycles land on ISSUE, and the display address points at a wall.
    vid_addr = 19'd102491;
    vid_pat = '{1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    pos_x0 = 10'd60; pos_y0 = 10'd60;
    run_probe(2'b01, 1'b1, n, a, b);
    chk("t8_latency", n, 12); chk("t8_ack", int'(a), 1); chk("t8_blocked", int'(b), 0);
    clear_pat();
    gap();

    // Reset during the WAIT state of corner 2.
    acks_before = ack_count;
    pos_x0 = 10'd60; pos_y0 = 10'd60;
    req = 2'b01;
    repeat (7) begin @(posedge clk_25m); #1; end
    rst = 1'b1;
    @(posedge clk_25m); #1;
    rst = 1'b0; req = 2'b00;
    #1;
    chk("t9_ack", int'(ack), 0);
    chk("t9_blocked", int'(blocked), 0);
    chk("t9_map_addr", int'(map_addr), 0);
    repeat (12) @(posedge clk_25m);
    #1;
    chk("t9_no_ack", ack_count, acks_before);
    run_probe(2'b01, 1'b1, n, a, b);
    chk("t9_next_latency", n, 10); chk("t9_next_ack", int'(a), 1);
    chk("t9_next_blocked", int'(b), 0);
    gap();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
